// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the
// bit-period divisor computation used by uart_rx and uart_tx.
// Contents: uart_state_t enumeration, calc_divisor() helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  // Clock cycles per line bit; the integer divide truncates, so the
  // accumulated error over one 10-bit frame stays well inside half a bit
  // for any sane clock/baud pairing.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Latency: 2 clk cycles from d to q; no backpressure (free-running).
// Ports: clk, rst (async active-high, both flops reset to 1 = line idle), d, q.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, emits one byte per frame.
// Latency: valid/frame_err pulse ~9.5 bit periods (+4 clk) after the start edge.
// Backpressure: none; valid is a one-cycle pulse and data holds until the next byte.
// Ports: clk, rst (async active-high), rx (idle high) -> data[7:0], valid,
//        frame_err, busy (state != IDLE).
// Build option: UART_RX_MAJORITY_EN enables 2-of-3 majority voting on every sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF    = DIVISOR / 2;
  localparam logic [15:0] DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  if (DIVISOR < 4 || DIVISOR > 65535) begin : g_divisor_check
    $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must lie in 4..65535");
  end

  uart_state_t state;
  logic [15:0] cnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        rx_s;
  logic        rx_d1;
  logic        rx_d2;
  logic        sample_bit;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Samples are taken from the one-cycle-delayed tap rx_d1 so that the
  // cycle after the nominal sample (rx_s) is already available for voting.
  // Both builds use the same tap, so frame timing does not change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  assign sample_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign sample_bit = rx_d1;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      shreg     <= 8'h00;
      bit_idx   <= 3'd0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 16'd0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= 16'd0;
            // A high line at mid-start-bit was only a glitch.
            state <= sample_bit ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == DIV_LAST) begin
            cnt     <= 16'd0;
            shreg   <= {sample_bit, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == DIV_LAST) begin
            cnt <= 16'd0;
            if (sample_bit) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          // A line stuck low (break) must not be mistaken for a start bit.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 27 MHz / 115200 baud (234 clocks per bit).
// Drives rx cycle by cycle at the falling clock edge; a monitor logs output
// pulses into a queue that each test compares against its expected queue.
module tb_uart_rx;

  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = DIV * 10;

  typedef struct {
    logic       is_err;
    logic [7:0] dat;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  both_cnt = 0;
  int  frame_start = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_rx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (valid) begin
      e.is_err = 1'b0; e.dat = data; e.cyc = cyc;
      obs_q.push_back(e);
    end
    if (frame_err) begin
      e.is_err = 1'b1; e.dat = data; e.cyc = cyc;
      obs_q.push_back(e);
    end
    if (valid && frame_err) both_cnt = both_cnt + 1;
  end

  function automatic ev_t mk_exp(input logic is_err, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err; e.dat = d; e.cyc = 0;
    return e;
  endfunction

  // One full 8N1 frame, one rx value per clock. glitch_at forces the line
  // high for that single cycle; stop_at ends the frame early (abort).
  task automatic drive_frame(input logic [7:0] b, input logic stop_v,
                             input int glitch_at, input int stop_at);
    logic v;
    for (int c = 0; c < FRAME; c++) begin
      if (c == stop_at) break;
      @(negedge clk);
      if (c < DIV)            v = 1'b0;
      else if (c < DIV * 9)   v = b[(c / DIV) - 1];
      else                    v = stop_v;
      if (c == glitch_at) v = 1'b1;
      rx = v;
      if (c == 0) frame_start = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_single_frame;
    ev_t e, o;
    exp_q.push_back(mk_exp(1'b0, 8'h55));
    drive_frame(8'h55, 1'b1, -1, -1);
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL single_frame: no output event, want err=%b data=%02h", e.is_err, e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL single_frame: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
        checks++;
        if (o.cyc - frame_start < 2200 || o.cyc - frame_start > 2250) begin
          errors++; $display("FAIL single_frame_latency: got %0d cycles want 2200..2250", o.cyc - frame_start);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_frame_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_start_glitch;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 60) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
      end
      rx = (c < 50) ? 1'b0 : 1'b1;
    end
    idle(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_frame_error;
    ev_t e, o;
    exp_q.push_back(mk_exp(1'b1, 8'h55));
    drive_frame(8'hA3, 1'b0, -1, -1);
    repeat (1000) begin
      @(negedge clk);
      rx = 1'b0;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL frame_error: no output event, want err=%b data=%02h", e.is_err, e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL frame_error: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL frame_error_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_error_wait_busy: got %b want 1", busy); end
    idle(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_error_release_busy: got %b want 0", busy); end
    exp_q.push_back(mk_exp(1'b0, 8'h12));
    drive_frame(8'h12, 1'b1, -1, -1);
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL frame_error_recover: no output event, want data=%02h", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL frame_error_recover: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
      end
    end
    checks++; if (data !== 8'h12) begin errors++; $display("FAIL frame_error_recover_data: got %02h want 12", data); end
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    exp_q.push_back(mk_exp(1'b0, 8'h00));
    exp_q.push_back(mk_exp(1'b0, 8'hFF));
    drive_frame(8'h00, 1'b1, -1, -1);
    drive_frame(8'hFF, 1'b1, -1, -1);
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL back_to_back: no output event, want data=%02h", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL back_to_back: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL back_to_back_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_midframe;
    ev_t e, o;
    // Abort in the middle of data bit 4.
    drive_frame(8'h3C, 1'b1, -1, DIV * 5 + DIV / 2);
    @(negedge clk);
    rx = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midframe_rst_data: got %02h want 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_rst_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midframe_rst_pulses: got valid=%b frame_err=%b want 0 0", valid, frame_err); end
    @(negedge clk);
    rst = 1'b0;
    idle(2500);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midframe_rst_events: got %0d events want 0", obs_q.size()); obs_q.delete(); end
    exp_q.push_back(mk_exp(1'b0, 8'h3C));
    drive_frame(8'h3C, 1'b1, -1, -1);
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL midframe_rst_recover: no output event, want data=%02h", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL midframe_rst_recover: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
      end
    end
  endtask

  task automatic test_sample_glitch;
    ev_t e, o;
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h04;
`endif
    exp_q.push_back(mk_exp(1'b0, want));
    // Bit 2 is sampled from the rx value captured 116 + 3*DIV cycles after the start edge.
    drive_frame(8'h00, 1'b1, DIV / 2 - 1 + 3 * DIV, -1);
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL sample_glitch: no output event, want data=%02h", e.dat);
      end else begin
        o = obs_q.pop_front();
        if (o.is_err !== e.is_err || o.dat !== e.dat) begin
          errors++; $display("FAIL sample_glitch: got err=%b data=%02h want err=%b data=%02h", o.is_err, o.dat, e.is_err, e.dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_start_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_sample_glitch();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_and_frame_err_together: got %0d cycles want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 27000000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  8  last received byte, held until next valid.
REQ-007 SHALL have port valid  output  1  one-cycle pulse, data holds a new byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-011 SHALL use DIVISOR = CLOCK_FREQUENCY/BAUD_RATE (integer divide) and HALF = DIVISOR/2, with a 16-bit bit-period counter; DIVISOR outside 4..65535 SHALL be a parameter error.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rx_s==0 -> START, counter cleared.
REQ-014 START: at counter==HALF-1, sample; 0 -> DATA with counter cleared, 1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-015 DATA: at each counter==DIVISOR-1, sample one bit into the shift register LSB-first and clear counter; after the 8th bit -> STOP.
REQ-016 STOP: at counter==DIVISOR-1, sample; 1 -> data updated, valid pulsed, -> IDLE; 0 -> frame_err pulsed, data unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1, then -> IDLE; a line held low SHALL never start a frame.
REQ-018 valid and frame_err SHALL be registered, asserted on the edge following the stop-bit sample, for exactly one cycle, and never together.
REQ-019 A start edge present in the cycle the FSM re-enters IDLE SHALL be detected on the next cycle; back-to-back frames with zero idle time SHALL all be received.

Reset
REQ-020 On rst: state IDLE, counter 0, shift register 0, data 0x00, valid 0, frame_err 0, busy 0, synchronizer 1; takes effect immediately, including mid-frame.
REQ-021 After rst release, a frame SHALL be accepted only from a fresh falling edge.

Configuration
REQ-022 With UART_RX_MAJORITY_EN defined, every sample (start, data, stop) SHALL be the 2-of-3 majority of rx_s at the nominal sample cycle and the cycles immediately before and after; without it, the single rx_s value at the nominal cycle SHALL be used; frame timing identical in both builds.

Structure
REQ-023 A shared package uart_pkg SHALL hold the state enumeration typedef and a divisor-computation function reused by uart_tx and uart_rx.
REQ-024 The 2-flop synchronizer SHALL be a sub-module named uart_sync.

Verification (CLOCK_FREQUENCY=27000000, BAUD_RATE=115200, DIVISOR=234)
REQ-025 Frame 0x55, 8N1 -> single valid pulse ~2223 cycles after start edge, data=0x55, frame_err never high.
REQ-026 rx low for 50 cycles then high -> no valid/frame_err, busy returns 0 within 120 cycles.
REQ-027 Frame 0xA3 with stop bit low, then rx low for 1000 cycles -> one frame_err pulse, valid 0, data unchanged, no further pulses until rx high and a new frame 0x12 -> data=0x12.
REQ-028 Frames 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-029 rst pulsed during data bit 4 of 0x3C -> all outputs 0 immediately, no pulse for the aborted frame; next full frame 0x3C -> data=0x3C.
REQ-030 Frame 0x00 with 1-cycle high glitch at bit 2 nominal sample -> with UART_RX_MAJORITY_EN data=0x00, without data=0x04.
